// File: rtl/cp0_timer_exc.sv
// Coprocessor-0: BadVAddr/Count/Compare/Status/Cause/EPC, timer and HW interrupts, exception/ERET redirect.
// Latency: flush and cp0_excaddr are combinational; register updates at the next edge; int_req_o one edge after Cause/Status.
// Backpressure: none; every event is taken in the cycle it is presented, and a same-cycle MTC0 loses to an exception or ERET.
module cp0_timer_exc #(
  parameter int unsigned HW_INT_NUM = 6,
  parameter int unsigned COUNT_DIV  = 2,
  parameter logic [31:0] EXC_ENTRY  = 32'hBFC00380,
  parameter logic [31:0] PC_RESET   = 32'hBFC00000
) (
  input  logic                  cpu_clk_50M,
  input  logic                  cpu_rst_n,
  input  logic                  we,
  input  logic [4:0]            waddr,
  input  logic [31:0]           wdata,
  input  logic                  re,
  input  logic [4:0]            raddr,
  output logic [31:0]           data_o,
  input  logic [HW_INT_NUM-1:0] int_i,
  input  logic [31:0]           pc_i,
  input  logic                  in_delay_i,
  input  logic [4:0]            exccode_i,
  input  logic [31:0]           badvaddr_i,
  output logic                  flush,
  output logic                  flush_im,
  output logic [31:0]           cp0_excaddr,
  output logic                  int_req_o,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o
);

  // Exception codes shared with the pipeline
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_NONE = 5'h10;
  localparam logic [4:0] EXC_ERET = 5'h11;

  localparam logic [4:0] A_BADVADDR = 5'd8;
  localparam logic [4:0] A_COUNT    = 5'd9;
  localparam logic [4:0] A_COMPARE  = 5'd11;
  localparam logic [4:0] A_STATUS   = 5'd12;
  localparam logic [4:0] A_CAUSE    = 5'd13;
  localparam logic [4:0] A_EPC      = 5'd14;

  localparam int unsigned DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  logic [31:0]      badvaddr_q, badvaddr_d;
  logic [31:0]      count_q, count_d;
  logic [31:0]      compare_q, compare_d;
  logic [31:0]      epc_q, epc_d;
  logic [7:0]       im_q, im_d;
  logic             exl_q, exl_d;
  logic             ie_q, ie_d;
  logic             bd_q, bd_d;
  logic             ti_q, ti_d;
  logic [7:0]       ip_q, ip_d;
  logic [4:0]       exc_q, exc_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             flush_im_q;
  logic             int_req_q, int_req_d;

  logic       ev, is_eret, is_exc, mtc;
  logic       wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  logic       tick, cnt_upd;
  logic [1:0] ip_sw_d;
  logic [5:0] ip_hw_d;

  // Decode the event and which MTC0 write survives it
  always_comb begin
    ev         = (exccode_i != EXC_NONE);
    is_eret    = (exccode_i == EXC_ERET);
    is_exc     = ev && !is_eret;
    mtc        = we && !ev;
    wr_count   = mtc && (waddr == A_COUNT);
    wr_compare = mtc && (waddr == A_COMPARE);
    wr_status  = mtc && (waddr == A_STATUS);
    wr_cause   = mtc && (waddr == A_CAUSE);
    wr_epc     = mtc && (waddr == A_EPC);
    tick       = (div_q == DIV_W'(COUNT_DIV - 1));
  end

  // Next state: divider/Count/Compare/TI, software register writes, exception and ERET effects
  always_comb begin
    div_d   = tick ? '0 : div_q + 1'b1;
    count_d = tick ? count_q + 32'd1 : count_q;
    cnt_upd = tick;
    if (wr_count) begin
      count_d = wdata;
      div_d   = '0;
      cnt_upd = 1'b1;
    end
    compare_d = wr_compare ? wdata : compare_q;
    ti_d = ti_q;
    if (wr_compare) begin
      ti_d = 1'b0;
    end else if (cnt_upd && (count_d == compare_q)) begin
      ti_d = 1'b1;
    end

    im_d       = wr_status ? wdata[15:8] : im_q;
    exl_d      = wr_status ? wdata[1] : exl_q;
    ie_d       = wr_status ? wdata[0] : ie_q;
    ip_sw_d    = wr_cause ? wdata[9:8] : ip_q[1:0];
    epc_d      = wr_epc ? wdata : epc_q;
    bd_d       = bd_q;
    exc_d      = exc_q;
    badvaddr_d = badvaddr_q;

    if (is_exc) begin
      // A nested exception keeps the original return point
      if (!exl_q) begin
        epc_d = in_delay_i ? pc_i - 32'd4 : pc_i;
        bd_d  = in_delay_i;
      end
      exl_d = 1'b1;
      exc_d = exccode_i;
      if ((exccode_i == EXC_ADEL) || (exccode_i == EXC_ADES)) begin
        badvaddr_d = badvaddr_i;
      end
    end else if (is_eret) begin
      exl_d = 1'b0;
    end
  end

  // Hardware interrupt pending bits resampled every cycle; the timer shares the top line
  always_comb begin
    ip_hw_d = '0;
    for (int i = 0; i < int'(HW_INT_NUM); i++) begin
      ip_hw_d[i] = int_i[i];
    end
    ip_hw_d[5] = ip_hw_d[5] | ti_d;
    ip_d       = {ip_hw_d, ip_sw_d};
    int_req_d  = ie_q & ~exl_q & (|(ip_q & im_q));
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge cpu_clk_50M) begin
    if (!cpu_rst_n) begin
      badvaddr_q <= '0;
      count_q    <= '0;
      compare_q  <= '0;
      epc_q      <= '0;
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ti_q       <= 1'b0;
      ip_q       <= '0;
      exc_q      <= EXC_NONE;
      div_q      <= '0;
      flush_im_q <= 1'b0;
      int_req_q  <= 1'b0;
    end else begin
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      epc_q      <= epc_d;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ti_q       <= ti_d;
      ip_q       <= ip_d;
      exc_q      <= exc_d;
      div_q      <= div_d;
      flush_im_q <= ev;
      int_req_q  <= int_req_d;
    end
  end

  // Architectural views, flush and redirect target
  always_comb begin
    status_o  = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
    cause_o   = {bd_q, ti_q, 14'b0, ip_q, 1'b0, exc_q, 2'b0};
    flush_im  = flush_im_q;
    int_req_o = int_req_q;
    flush     = cpu_rst_n && ev;
    if (!cpu_rst_n) begin
      cp0_excaddr = PC_RESET;
    end else if (!ev) begin
      cp0_excaddr = '0;
    end else if (is_eret) begin
      // A same-cycle MTC0 to EPC is forwarded to the return target
      cp0_excaddr = (we && (waddr == A_EPC)) ? wdata : epc_q;
    end else begin
      cp0_excaddr = EXC_ENTRY;
    end
  end

  // MFC0 read mux; returns the pre-write value of a register written this cycle
  always_comb begin
    data_o = '0;
    if (cpu_rst_n && re) begin
      case (raddr)
        A_BADVADDR: data_o = badvaddr_q;
        A_COUNT:    data_o = count_q;
        A_COMPARE:  data_o = compare_q;
        A_STATUS:   data_o = status_o;
        A_CAUSE:    data_o = cause_o;
        A_EPC:      data_o = epc_q;
        default:    data_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_timer_exc.sv
// Bench for cp0_timer_exc: directed scenarios then random traffic against a behavioural model.
// Inputs change 1 time unit after the rising edge; outputs are checked mid-cycle and just after the edge.
// The DUT has no backpressure; the bench drives one event per cycle.
module tb_cp0_timer_exc;

  localparam int          DIV      = 2;
  localparam logic [31:0] ENTRY    = 32'hBFC00380;
  localparam logic [31:0] PC_RST   = 32'hBFC00000;
  localparam logic [4:0]  C_ADEL   = 5'h04;
  localparam logic [4:0]  C_ADES   = 5'h05;
  localparam logic [4:0]  C_SYS    = 5'h08;
  localparam logic [4:0]  C_RI     = 5'h0A;
  localparam logic [4:0]  C_NONE   = 5'h10;
  localparam logic [4:0]  C_ERET   = 5'h11;

  logic        clk = 1'b0;
  logic        rst_n, we, re, in_delay_i;
  logic [4:0]  waddr, raddr, exccode_i;
  logic [31:0] wdata, pc_i, badvaddr_i;
  logic [5:0]  int_i;
  logic [31:0] data_o, cp0_excaddr, status_o, cause_o;
  logic        flush, flush_im, int_req_o;

  always #5 clk = ~clk;

  cp0_timer_exc #(.HW_INT_NUM(6), .COUNT_DIV(DIV), .EXC_ENTRY(ENTRY), .PC_RESET(PC_RST)) dut (
    .cpu_clk_50M(clk), .cpu_rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .data_o(data_o), .int_i(int_i), .pc_i(pc_i),
    .in_delay_i(in_delay_i), .exccode_i(exccode_i), .badvaddr_i(badvaddr_i),
    .flush(flush), .flush_im(flush_im), .cp0_excaddr(cp0_excaddr),
    .int_req_o(int_req_o), .status_o(status_o), .cause_o(cause_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference architectural state
  logic [31:0] m_status, m_cause, m_count, m_compare, m_epc, m_badv;
  int          m_phase;
  logic        m_flush_im, m_int_req;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_badv;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  // Advance the reference by one clock edge using the current inputs
  task automatic model_step();
    logic        ev, eret, exc, mtc, upd, ti, bd;
    logic [1:0]  ip_sw;
    logic [4:0]  code;
    logic [31:0] n_count, n_status, n_epc, n_badv;
    if (!rst_n) begin
      m_status = 32'h00400000; m_cause = {25'b0, C_NONE, 2'b0};
      m_count = 0; m_compare = 0; m_epc = 0; m_badv = 0; m_phase = 0;
      m_flush_im = 1'b0; m_int_req = 1'b0;
      return;
    end
    ev   = (exccode_i != C_NONE);
    eret = (exccode_i == C_ERET);
    exc  = ev && !eret;
    mtc  = we && !ev;
    m_int_req  = m_status[0] & ~m_status[1] & (|(m_cause[15:8] & m_status[15:8]));
    m_flush_im = ev;
    // Count advances once every DIV cycles; a software write restarts the divider
    upd = 1'b0;
    n_count = m_count;
    m_phase = m_phase + 1;
    if (m_phase == DIV) begin
      m_phase = 0; n_count = m_count + 32'd1; upd = 1'b1;
    end
    if (mtc && waddr == 5'd9) begin
      n_count = wdata; m_phase = 0; upd = 1'b1;
    end
    ti = m_cause[30];
    if (mtc && waddr == 5'd11) ti = 1'b0;
    else if (upd && n_count == m_compare) ti = 1'b1;
    if (mtc && waddr == 5'd11) m_compare = wdata;
    m_count = n_count;
    n_status = m_status;
    if (mtc && waddr == 5'd12) n_status = (wdata & 32'h0000FF03) | 32'h00400000;
    ip_sw = m_cause[9:8];
    if (mtc && waddr == 5'd13) ip_sw = wdata[9:8];
    n_epc = (mtc && waddr == 5'd14) ? wdata : m_epc;
    n_badv = m_badv;
    bd = m_cause[31];
    code = m_cause[6:2];
    if (exc) begin
      if (!m_status[1]) begin
        n_epc = in_delay_i ? pc_i - 32'd4 : pc_i;
        bd = in_delay_i;
      end
      n_status[1] = 1'b1;
      code = exccode_i;
      if (exccode_i == C_ADEL || exccode_i == C_ADES) n_badv = badvaddr_i;
    end else if (eret) begin
      n_status[1] = 1'b0;
    end
    m_status = n_status; m_epc = n_epc; m_badv = n_badv;
    m_cause = {bd, ti, 14'b0, int_i[5] | ti, int_i[4:0], ip_sw, 1'b0, code, 2'b0};
  endtask

  // One cycle: check combinational outputs mid-cycle, take the edge, check registered outputs
  task automatic step();
    logic [31:0] e_addr, e_data;
    logic        e_flush;
    #2;
    if (!rst_n) begin
      e_flush = 1'b0; e_addr = PC_RST; e_data = 32'h0;
    end else begin
      e_flush = (exccode_i != C_NONE);
      if (!e_flush)                 e_addr = 32'h0;
      else if (exccode_i == C_ERET) e_addr = (we && waddr == 5'd14) ? wdata : m_epc;
      else                          e_addr = ENTRY;
      e_data = re ? m_read(raddr) : 32'h0;
    end
    chk1("flush", flush, e_flush);
    chk32("cp0_excaddr", cp0_excaddr, e_addr);
    chk32("data_o", data_o, e_data);
    model_step();
    @(posedge clk);
    #1;
    chk32("status_o", status_o, m_status);
    chk32("cause_o", cause_o, m_cause);
    chk1("flush_im", flush_im, m_flush_im);
    chk1("int_req_o", int_req_o, m_int_req);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    step();
    we = 1'b0;
  endtask

  initial begin
    logic [4:0] rd_list [3];
    rst_n = 1'b0; we = 1'b0; re = 1'b1; waddr = 5'd0; wdata = 32'h0; raddr = 5'd9;
    int_i = 6'h0; pc_i = 32'h0; in_delay_i = 1'b0; exccode_i = C_ERET; badvaddr_i = 32'h0;
    rd_list[0] = 5'd9; rd_list[1] = 5'd12; rd_list[2] = 5'd13;
    #1;

    // Reset held for three cycles with ERET presented
    for (int i = 0; i < 3; i++) begin
      raddr = rd_list[i];
      step();
    end
    chk32("reset_status", status_o, 32'h00400000);
    rst_n = 1'b1; exccode_i = C_NONE; re = 1'b0;

    // Timer: Compare=5, Count=0, IE and IM7 enabled
    mtc0(5'd12, 32'h00008001);
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 9)  chk1("ti_before_match", cause_o[30], 1'b0);
      if (i == 10) chk1("ti_at_match", cause_o[30], 1'b1);
    end
    step();
    chk1("timer_int_req", int_req_o, 1'b1);
    mtc0(5'd11, 32'd100);
    chk1("ti_cleared", cause_o[30], 1'b0);

    // Count wraps from all-ones to zero
    mtc0(5'd9, 32'hFFFFFFFF);
    step();
    step();
    re = 1'b1; raddr = 5'd9; #2;
    chk32("count_wrap", data_o, 32'h0);
    re = 1'b0;
    step();

    // Delay-slot address fault
    exccode_i = C_ADEL; pc_i = 32'hBFC00104; in_delay_i = 1'b1; badvaddr_i = 32'h1;
    #2;
    chk1("adel_flush", flush, 1'b1);
    chk32("adel_target", cp0_excaddr, ENTRY);
    step();
    chk1("adel_flush_im", flush_im, 1'b1);
    chk1("adel_bd", cause_o[31], 1'b1);
    chk32("adel_exccode", {27'b0, cause_o[6:2]}, 32'd4);
    exccode_i = C_NONE; in_delay_i = 1'b0; re = 1'b1; raddr = 5'd14; #2;
    chk32("adel_epc", data_o, 32'hBFC00100);
    raddr = 5'd8; #1;
    chk32("adel_badvaddr", data_o, 32'h1);
    step();

    // Nested exception leaves EPC alone
    exccode_i = C_RI; pc_i = 32'h80;
    step();
    chk32("nested_exccode", {27'b0, cause_o[6:2]}, 32'd10);
    exccode_i = C_NONE; raddr = 5'd14; #2;
    chk32("nested_epc", data_o, 32'hBFC00100);
    step();

    // ERET with a same-cycle MTC0 to EPC
    exccode_i = C_ERET; we = 1'b1; waddr = 5'd14; wdata = 32'h1234; #2;
    chk32("eret_fwd", cp0_excaddr, 32'h1234);
    step();
    we = 1'b0; exccode_i = C_NONE;
    chk1("eret_exl", status_o[1], 1'b0);
    step();

    // Interrupt masking
    mtc0(5'd12, 32'h00000001);
    int_i = 6'h01;
    step();
    step();
    chk1("masked_int", int_req_o, 1'b0);
    mtc0(5'd12, 32'h00000401);
    step();
    chk1("unmasked_int", int_req_o, 1'b1);
    mtc0(5'd12, 32'h00000403);
    step();
    chk1("exl_blocks_int", int_req_o, 1'b0);

    // Random traffic against the reference
    for (int n = 0; n < 800; n++) begin
      int k;
      rst_n = ($urandom_range(0, 99) != 0);
      we = ($urandom_range(0, 2) == 0);
      k = $urandom_range(0, 6);
      case (k)
        0: waddr = 5'd8;
        1: waddr = 5'd9;
        2: waddr = 5'd11;
        3: waddr = 5'd12;
        4: waddr = 5'd13;
        5: waddr = 5'd14;
        default: waddr = 5'($urandom_range(0, 31));
      endcase
      wdata = $urandom;
      if (waddr == 5'd9) wdata = m_compare - 32'($urandom_range(0, 3));
      re = ($urandom_range(0, 1) == 1);
      raddr = 5'($urandom_range(7, 15));
      if ($urandom_range(0, 7) == 0) int_i = 6'($urandom_range(0, 63));
      k = $urandom_range(0, 19);
      case (k)
        0: exccode_i = C_ADEL;
        1: exccode_i = C_ADES;
        2: exccode_i = C_RI;
        3: exccode_i = C_ERET;
        4: exccode_i = C_SYS;
        default: exccode_i = C_NONE;
      endcase
      pc_i = $urandom;
      badvaddr_i = $urandom;
      in_delay_i = ($urandom_range(0, 1) == 1);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
